regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Arbitrates the register file's single write port between the in-order writeback stage and a long-latency multi-cycle unit (mul/div) whose results return out of band. Buffers multi-cycle results in a small FIFO, drains them in cycles the writeback stage leaves free, and raises a stall request when a buffered result has been starved too long. Keeps a per-register pending scoreboard so decode can hold instructions that read a register awaiting a multi-cycle result.

## Interface
- DEPTH, 2, multi-cycle result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before stall_req asserts (≥1)

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- pipe_wr_en  in  1  writeback stage wants to write this cycle
- pipe_rd  in  5  writeback destination tag
- pipe_data  in  32  writeback value
- mc_valid  in  1  multi-cycle unit presents a result
- mc_ready  out  1  FIFO can accept a result
- mc_rd  in  5  result destination tag
- mc_data  in  32  result value
- mc_issue  in  1  a multi-cycle op is dispatched this cycle
- mc_issue_rd  in  5  destination of the dispatched op
- query_rs1, query_rs2  in  5 each  source tags from decode
- rs1_pending, rs2_pending  out  1 each  queried register awaits a multi-cycle result
- wr_en  out  1  register file write enable
- wr_rd  out  5  register file write tag
- wr_data  out  32  register file write value
- stall_req  out  1  request upstream to insert a bubble at writeback
- fifo_count  out  $clog2(DEPTH)+1  entries buffered

## Operation
- Pipe write is effective when pipe_wr_en=1 and pipe_rd≠0. It always owns the port; it is never delayed.
- FIFO head drains (wr_en=1, wr_rd/wr_data from head, pop) only in cycles with no effective pipe write. An entry with rd=0 pops without asserting wr_en.
- With no effective pipe write and an empty FIFO: wr_en=0, wr_rd=0, wr_data=0.
- Enqueue on mc_valid & mc_ready. mc_ready = (fifo_count < DEPTH), a function of registered count only. There is no same-cycle drain credit and no bypass, so an entry enqueued in cycle N drains no earlier than N+1.
- FIFO order is strict in-order. Pointers wrap modulo DEPTH.
- Scoreboard holds 32 pending bits; bit 0 is hard-wired 0.
  - Set on mc_issue with mc_issue_rd≠0.
  - Cleared when the FIFO head with that rd drains.
  - Set and clear of the same rd in one cycle: set wins.
- rsN_pending = pending[query_rsN], combinational from registered bits. No forwarding of a same-cycle drain: the bit clears the following cycle.
- Starvation: an age counter counts cycles the FIFO is non-empty and the head did not drain. It resets to 0 on every pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - stall_req is a registered output: 1 while age ≥ STARVE_LIMIT, cleared the cycle after the head drains.
  - Upstream guarantees pipe_wr_en=0 in the cycle after stall_req is seen high.

## Timing
- Reset (asynchronous, reset_n=0):
  - FIFO empty, fifo_count=0, mc_ready=1.
  - Scoreboard all 0, age=0, stall_req=0, wr_en=0.
  - Buffered results and pending bits are discarded; a reset mid-operation loses in-flight results by design.
- wr_* outputs are combinational from pipe inputs and the FIFO head. The register file samples them on the next rising edge.
- Latency from mc_valid&mc_ready to write: ≥1 cycle, exactly 1 when no pipe writes intervene.
- Full FIFO: mc_ready=0. The multi-cycle unit holds mc_valid and mc_rd/mc_data stable until accepted.
- Pop and push in the same cycle (count<DEPTH): count unchanged, pointers both advance.
- stall_req rises STARVE_LIMIT+1 cycles after the head first waits.

## Test plan
- Reset with FIFO holding 2 entries and pending bits set → fifo_count=0, mc_ready=1, all pending=0, wr_en=0, stall_req=0.
- Idle pipe; mc_valid with rd=5, data=0x1234 in cycle 0 → cycle 1: wr_en=1, wr_rd=5, wr_data=0x1234; pending[5] cleared in cycle 2.
- pipe_wr_en held 1 (rd=3) for 12 cycles, one FIFO entry rd=7 queued:
  - stall_req=1 from cycle 9.
  - Pipe drops → rd=7 written that cycle, stall_req=0 the next cycle.
- Fill FIFO with DEPTH=2 entries, mc_valid still high → mc_ready=0, third result held. After one drain → accepted; write order matches enqueue order.
- mc_issue rd=9 in the same cycle the FIFO head rd=9 drains → pending[9] stays 1. mc_issue rd=0 → no bit set. FIFO entry rd=0 pops with wr_en=0.
- query_rs1=9, query_rs2=0 with pending[9]=1 → rs1_pending=1, rs2_pending=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the register file's single write port between the in-order
// writeback stage and a long-latency multi-cycle unit (mul/div).
// Multi-cycle results are queued in a small FIFO. The queue drains only in
// cycles the writeback stage leaves free. A stall request is raised when
// the FIFO head has waited too long. A per-register pending scoreboard lets
// decode hold readers of registers that still await a multi-cycle result.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   pipe_wr_en/rd/data      writeback stage write request (always wins)
//   mc_valid/rd/data        multi-cycle result offered to the FIFO
//   mc_ready                FIFO has room (registered count only)
//   mc_issue/mc_issue_rd    multi-cycle op dispatched; marks rd pending
//   query_rs1/2             decode source tags
//   rs1_pending/rs2_pending queried register awaits a multi-cycle result
//   wr_en/wr_rd/wr_data     register file write port
//   stall_req               registered request to insert a writeback bubble
//   fifo_count              number of buffered results
module regfile_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     pipe_wr_en,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  input  logic                     mc_valid,
  output logic                     mc_ready,
  input  logic [4:0]               mc_rd,
  input  logic [31:0]              mc_data,
  input  logic                     mc_issue,
  input  logic [4:0]               mc_issue_rd,
  input  logic [4:0]               query_rs1,
  input  logic [4:0]               query_rs2,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
  output logic                     wr_en,
  output logic [4:0]               wr_rd,
  output logic [31:0]              wr_data,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(STARVE_LIMIT);

  logic [4:0]       mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [31:0]      pending;
  logic [31:0]      pending_next;
  logic [AGE_W-1:0] age;

  logic       pipe_eff;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic [4:0] head_rd;

  // A pipe write to x0 is a no-op, so it does not claim the port.
  assign pipe_eff   = pipe_wr_en && (pipe_rd != 5'd0);
  assign fifo_empty = (count == '0);
  assign head_rd    = mem_rd[head];
  assign pop        = !pipe_eff && !fifo_empty;
  assign mc_ready   = (count < DEPTH_C);
  assign push       = mc_valid && mc_ready;
  assign fifo_count = count;

  // Port mux: the pipe always wins; otherwise the FIFO head drains.
  // A head entry targeting x0 is discarded without a write.
  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    if (pipe_eff) begin
      wr_en   = 1'b1;
      wr_rd   = pipe_rd;
      wr_data = pipe_data;
    end else if (pop && (head_rd != 5'd0)) begin
      wr_en   = 1'b1;
      wr_rd   = head_rd;
      wr_data = mem_data[head];
    end
  end

  // Result storage needs no reset: only entries covered by count are used.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_rd[tail]   <= mc_rd;
      mem_data[tail] <= mc_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A set in the same cycle as a clear of the same register wins,
  // because a fresh op to that register is now in flight.
  always_comb begin
    pending_next = pending;
    if (pop && (head_rd != 5'd0)) pending_next[head_rd] = 1'b0;
    if (mc_issue && (mc_issue_rd != 5'd0)) pending_next[mc_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_next;
  end

  assign rs1_pending = pending[query_rs1];
  assign rs2_pending = pending[query_rs2];

  // Age counts cycles the head sits unserved. stall_req is registered
  // from the current age, so it rises one cycle after age saturates.
  // It drops right after the head drains.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      age       <= '0;
      stall_req <= 1'b0;
    end else begin
      if (fifo_empty || pop)  age <= '0;
      else if (age < LIMIT_C) age <= age + 1'b1;
      stall_req <= !pop && (age >= LIMIT_C);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed test of regfile_write_arbiter with DEPTH=2, STARVE_LIMIT=8.
// Expected register-file writes, tagged with their cycle number, are queued
// when the stimulus is issued. A monitor checks every write on the falling
// edge. Status outputs are checked directly by the stimulus process.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pipe_wr_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic [4:0]  query_rs1;
  logic [4:0]  query_rs2;
  logic        rs1_pending;
  logic        rs2_pending;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic        stall_req;
  logic [1:0]  fifo_count;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  regfile_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .stall_req(stall_req), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  // Free-running cycle number; a cycle starts at its rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic expectWrite(input int c, input logic [4:0] rd,
                             input logic [31:0] data);
    exp_t e;
    e.cyc  = c;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Drives one cycle of inputs just after the rising edge and queues the
  // expected write of any effective pipe write in that same cycle.
  task automatic applyStimulus(input logic pwe, input logic [4:0] prd,
                               input logic [31:0] pd, input logic mv,
                               input logic [4:0] mrd, input logic [31:0] md,
                               input logic iss, input logic [4:0] ird);
    @(posedge clock);
    #1;
    pipe_wr_en  = pwe;
    pipe_rd     = prd;
    pipe_data   = pd;
    mc_valid    = mv;
    mc_rd       = mrd;
    mc_data     = md;
    mc_issue    = iss;
    mc_issue_rd = ird;
    if (pwe && (prd != 5'd0)) expectWrite(cyc, prd, pd);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // Monitor: retire overdue expectations, then match each write.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL missed_write: got none expected rd=%0d data=0x%0h in cycle %0d",
               exp_q[0].rd, exp_q[0].data, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (reset_n && wr_en) begin
      vectors++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write: got rd=%0d data=0x%0h expected no write in cycle %0d",
                 wr_rd, wr_data, cyc);
      end else begin
        if (wr_rd !== exp_q[0].rd || wr_data !== exp_q[0].data) begin
          miscompares++;
          $display("[TB] FAIL write_value: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h",
                   wr_rd, wr_data, exp_q[0].rd, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    pipe_wr_en  = 1'b0;
    pipe_rd     = 5'd0;
    pipe_data   = 32'd0;
    mc_valid    = 1'b0;
    mc_rd       = 5'd0;
    mc_data     = 32'd0;
    mc_issue    = 1'b0;
    mc_issue_rd = 5'd0;
    query_rs1   = 5'd0;
    query_rs2   = 5'd0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("reset_mc_ready", 32'(mc_ready), 32'd1);
    checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset_stall_req", 32'(stall_req), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Fill the FIFO and set pending bits behind pipe writes, then reset.
    applyStimulus(1'b1, 5'd1, 32'hA1, 1'b1, 5'd4, 32'hD4, 1'b1, 5'd4);
    applyStimulus(1'b1, 5'd1, 32'hA2, 1'b1, 5'd6, 32'hD6, 1'b1, 5'd6);
    applyStimulus(1'b1, 5'd1, 32'hA3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    query_rs1 = 5'd4;
    query_rs2 = 5'd6;
    @(negedge clock);
    checkOutput("full_fifo_count", 32'(fifo_count), 32'd2);
    checkOutput("full_mc_ready", 32'(mc_ready), 32'd0);
    checkOutput("pre_reset_pend4", 32'(rs1_pending), 32'd1);
    checkOutput("pre_reset_pend6", 32'(rs2_pending), 32'd1);
    #1;
    reset_n    = 1'b0;
    pipe_wr_en = 1'b0;
    #1;
    checkOutput("midrst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("midrst_mc_ready", 32'(mc_ready), 32'd1);
    checkOutput("midrst_pend4", 32'(rs1_pending), 32'd0);
    checkOutput("midrst_pend6", 32'(rs2_pending), 32'd0);
    checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst_stall_req", 32'(stall_req), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single result with an idle pipe: written the next cycle.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    query_rs1 = 5'd5;
    query_rs2 = 5'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0);
    expectWrite(cyc + 1, 5'd5, 32'h1234);
    @(negedge clock);
    checkOutput("pend5_after_issue", 32'(rs1_pending), 32'd1);
    idleCycle();
    @(negedge clock);
    checkOutput("pend5_drain_cycle", 32'(rs1_pending), 32'd1);
    idleCycle();
    @(negedge clock);
    checkOutput("pend5_cleared", 32'(rs1_pending), 32'd0);

    // Starvation: pipe owns the port for 12 cycles while rd=7 waits.
    applyStimulus(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 5'd3, 32'h301 + 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      @(negedge clock);
      checkOutput($sformatf("stall_cycle_%0d", k), 32'(stall_req), 32'(k >= 9));
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    expectWrite(cyc, 5'd7, 32'h77);
    @(negedge clock);
    checkOutput("stall_on_drain", 32'(stall_req), 32'd1);
    idleCycle();
    @(negedge clock);
    checkOutput("stall_after_drain", 32'(stall_req), 32'd0);

    // Full FIFO back-pressure and in-order drain.
    applyStimulus(1'b1, 5'd2, 32'h201, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd2, 32'h202, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd2, 32'h203, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0);
    @(negedge clock);
    checkOutput("bp_mc_ready_a", 32'(mc_ready), 32'd0);
    checkOutput("bp_count_a", 32'(fifo_count), 32'd2);
    applyStimulus(1'b1, 5'd2, 32'h204, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0);
    @(negedge clock);
    checkOutput("bp_mc_ready_b", 32'(mc_ready), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0);
    expectWrite(cyc, 5'd10, 32'hA0);
    @(negedge clock);
    checkOutput("bp_mc_ready_c", 32'(mc_ready), 32'd0);
    checkOutput("bp_count_c", 32'(fifo_count), 32'd2);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0);
    expectWrite(cyc, 5'd11, 32'hB0);
    @(negedge clock);
    checkOutput("bp_mc_ready_d", 32'(mc_ready), 32'd1);
    checkOutput("bp_count_d", 32'(fifo_count), 32'd1);
    idleCycle();
    expectWrite(cyc, 5'd12, 32'hC0);
    @(negedge clock);
    checkOutput("pushpop_count", 32'(fifo_count), 32'd1);
    idleCycle();
    @(negedge clock);
    checkOutput("idle_count", 32'(fifo_count), 32'd0);
    checkOutput("idle_wr_en", 32'(wr_en), 32'd0);
    checkOutput("idle_wr_rd", 32'(wr_rd), 32'd0);
    checkOutput("idle_wr_data", wr_data, 32'd0);

    // Set wins over a same-cycle clear; x0 is never pending.
    applyStimulus(1'b1, 5'd2, 32'h205, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    expectWrite(cyc, 5'd9, 32'h99);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    query_rs1 = 5'd9;
    query_rs2 = 5'd0;
    @(negedge clock);
    checkOutput("pend9_set_wins", 32'(rs1_pending), 32'd1);
    checkOutput("pend0_query", 32'(rs2_pending), 32'd0);
    idleCycle();
    query_rs1 = 5'd0;
    @(negedge clock);
    checkOutput("pend0_after_issue0", 32'(rs1_pending), 32'd0);

    // A result for x0 pops silently.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0);
    idleCycle();
    @(negedge clock);
    checkOutput("x0_entry_count", 32'(fifo_count), 32'd1);
    checkOutput("x0_pop_wr_en", 32'(wr_en), 32'd0);
    idleCycle();
    @(negedge clock);
    checkOutput("x0_popped_count", 32'(fifo_count), 32'd0);

    // A pipe write to x0 leaves the port free for the FIFO head.
    applyStimulus(1'b1, 5'd2, 32'h206, 1'b1, 5'd13, 32'hD13, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    expectWrite(cyc, 5'd13, 32'hD13);
    idleCycle();
    idleCycle();
    @(negedge clock);
    checkOutput("writes_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
